// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone generator: semitone frequency table,
// half-period helper and the player state encoding.
package piano_pkg;

    localparam int NUM_SEMI = 12;

    // Centi-Hz frequencies for C4..B4
    localparam int unsigned NOTE_CHZ [NUM_SEMI] = '{
        26163, 27718, 29366, 31113, 32963, 34923,
        36999, 39200, 41530, 44000, 46616, 49388
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [63:0] base_half(input logic [63:0] clk_hz, input int idx);
        return (clk_hz * 64'd100) / (64'd2 * 64'(NOTE_CHZ[idx]));
    endfunction

endpackage

// File: rtl/note_half_lut.sv
// Combinational half-period lookup: constant ROM of octave-4 half-periods,
// shifted down by the octave select and clamped to a minimum.
module note_half_lut
    import piano_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int CNT_W    = 24,
    parameter int OCT_W    = 2,
    parameter int MIN_HALF = 2
)
(
    input  logic [3:0]       i_note_sel,
    input  logic [OCT_W-1:0] i_octave,
    output logic [CNT_W-1:0] o_half
);

    logic [CNT_W-1:0] w_rom [NUM_SEMI];
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_shift;

    // Table entries are elaboration-time constants, so no divider is built
    for (genvar g = 0; g < NUM_SEMI; g++) begin : g_rom
        localparam logic [63:0] HALF = base_half(64'(CLK_HZ), g);
        assign w_rom[g] = HALF[CNT_W-1:0];
    end

    always_comb begin
        w_base = '0;
        for (int i = 0; i < NUM_SEMI; i++) begin
            if (i_note_sel == 4'(i)) begin
                w_base = w_rom[i];
            end
        end
        w_shift = w_base >> i_octave;
        o_half  = (w_shift < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : w_shift;
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: plays any semitone over several octaves, with
// note changes and releases applied only at half-period boundaries.
module note_tone_gen
    import piano_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int CNT_W    = 24,
    parameter int OCT_W    = 2,
    parameter int MIN_HALF = 2
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_note_req,
    input  logic [3:0]       i_note_sel,
    input  logic [OCT_W-1:0] i_octave,
    input  logic             i_note_off,
    output logic             o_tone_out,
    output logic             o_busy,
    output logic [3:0]       o_active_note,
    output logic             o_req_err
);

    if (base_half(64'(CLK_HZ), 0) > ((64'd1 << CNT_W) - 64'd1)) begin : g_half_range
        $error("note_tone_gen: CNT_W too narrow for the longest half-period");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend_half;
    logic [3:0]       r_pend_note;
    logic             r_pend_valid;
    logic             r_tone;
    logic [3:0]       r_active;
    logic             r_req_err;

    logic [CNT_W-1:0] w_half;
    logic             w_valid;
    logic             w_off;
    logic             w_boundary;
    logic             w_next_valid;
    logic [CNT_W-1:0] w_next_half;
    logic [3:0]       w_next_note;

    note_half_lut #(
        .CLK_HZ   (CLK_HZ),
        .CNT_W    (CNT_W),
        .OCT_W    (OCT_W),
        .MIN_HALF (MIN_HALF)
    ) u_lut (
        .i_note_sel (i_note_sel),
        .i_octave   (i_octave),
        .o_half     (w_half)
    );

    // An invalid request is ignored entirely, so it does not mask note_off
    assign w_valid      = i_note_req && (i_note_sel < 4'(NUM_SEMI));
    assign w_off        = i_note_off && !w_valid;
    assign w_boundary   = (r_state != IDLE) && (r_cnt == r_half - CNT_W'(1));
    assign w_next_valid = w_valid || r_pend_valid;
    assign w_next_half  = w_valid ? w_half : r_pend_half;
    assign w_next_note  = w_valid ? i_note_sel : r_pend_note;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_half       <= '0;
            r_pend_half  <= '0;
            r_pend_note  <= '0;
            r_pend_valid <= 1'b0;
            r_tone       <= 1'b0;
            r_active     <= '0;
            r_req_err    <= 1'b0;
        end else begin
            r_req_err <= i_note_req && !w_valid;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_half   <= w_half;
                        r_cnt    <= '0;
                        r_tone   <= 1'b1;
                        r_active <= i_note_sel;
                        r_state  <= PLAY;
                    end
                end
                PLAY: begin
                    if (w_boundary) begin
                        r_cnt        <= '0;
                        r_tone       <= ~r_tone;
                        r_pend_valid <= 1'b0;
                        if (w_off) begin
                            r_state <= RELEASE;
                        end else if (w_next_valid) begin
                            r_half   <= w_next_half;
                            r_active <= w_next_note;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_valid) begin
                            r_pend_valid <= 1'b1;
                            r_pend_half  <= w_half;
                            r_pend_note  <= i_note_sel;
                        end else if (w_off) begin
                            r_state      <= RELEASE;
                            r_pend_valid <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    if (w_boundary) begin
                        r_cnt        <= '0;
                        r_pend_valid <= 1'b0;
                        if (w_next_valid) begin
                            r_tone   <= ~r_tone;
                            r_half   <= w_next_half;
                            r_active <= w_next_note;
                            r_state  <= PLAY;
                        end else begin
                            r_tone   <= 1'b0;
                            r_active <= '0;
                            r_state  <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_valid) begin
                            r_pend_valid <= 1'b1;
                            r_pend_half  <= w_half;
                            r_pend_note  <= i_note_sel;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_tone_out    = r_tone;
    assign o_busy        = (r_state != IDLE);
    assign o_active_note = r_active;
    assign o_req_err     = r_req_err;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen at CLK_HZ=1 MHz: directed scenarios plus random
// note traffic, all checked cycle by cycle against a behavioural player model.
module tb_note_tone_gen;

    localparam int CLK_HZ = 1_000_000;
    localparam int CNT_W  = 24;
    localparam int OCT_W  = 2;

    logic             clock;
    logic             resetN;
    logic             noteReq;
    logic [3:0]       noteSel;
    logic [OCT_W-1:0] octave;
    logic             noteOff;
    logic             toneOut;
    logic             busy;
    logic [3:0]       activeNote;
    logic             reqErr;

    int checkCount = 0;
    int passCount  = 0;

    int chzTab [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                        36999, 39200, 41530, 44000, 46616, 49388};

    // Model: 0 silent, 1 sounding, 2 releasing; age = cycles current level has lasted
    int mState, mTone, mActive, mHalf, mAge, mErr;
    int mPendValid, mPendNote, mPendHalf;

    note_tone_gen #(
        .CLK_HZ   (CLK_HZ),
        .CNT_W    (CNT_W),
        .OCT_W    (OCT_W),
        .MIN_HALF (2)
    ) dut (
        .i_clk         (clock),
        .i_rst_n       (resetN),
        .i_note_req    (noteReq),
        .i_note_sel    (noteSel),
        .i_octave      (octave),
        .i_note_off    (noteOff),
        .o_tone_out    (toneOut),
        .o_busy        (busy),
        .o_active_note (activeNote),
        .o_req_err     (reqErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    function automatic int halfOf(input int sel, input int oct);
        longint b;
        b = (longint'(CLK_HZ) * 100) / (2 * longint'(chzTab[sel]));
        b = b >>> oct;
        if (b < 2) b = 2;
        return int'(b);
    endfunction

    task automatic modelReset();
        mState = 0; mTone = 0; mActive = 0; mHalf = 0; mAge = 0; mErr = 0;
        mPendValid = 0; mPendNote = 0; mPendHalf = 0;
    endtask

    task automatic modelStep();
        int valid, offEff, h, haveNext, nNote, nHalf;
        if (!resetN) begin
            modelReset();
            return;
        end
        valid  = (noteReq && noteSel < 12) ? 1 : 0;
        offEff = (noteOff && !valid) ? 1 : 0;
        h      = valid ? halfOf(noteSel, octave) : 0;
        mErr   = (noteReq && noteSel >= 12) ? 1 : 0;
        if (mState == 0) begin
            if (valid) begin
                mState = 1; mTone = 1; mActive = noteSel; mHalf = h; mAge = 1;
            end
        end else if (mAge == mHalf) begin
            haveNext = valid || mPendValid;
            nNote = valid ? int'(noteSel) : mPendNote;
            nHalf = valid ? h : mPendHalf;
            mAge = 1;
            mPendValid = 0;
            if (mState == 1) begin
                mTone = 1 - mTone;
                if (offEff) mState = 2;
                else if (haveNext) begin mActive = nNote; mHalf = nHalf; end
            end else if (haveNext) begin
                mTone = 1 - mTone; mActive = nNote; mHalf = nHalf; mState = 1;
            end else begin
                mTone = 0; mActive = 0; mState = 0;
            end
        end else begin
            mAge++;
            if (valid) begin
                mPendValid = 1; mPendNote = noteSel; mPendHalf = h;
            end else if (offEff && mState == 1) begin
                mState = 2; mPendValid = 0;
            end
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clock);
        #1;
        checkOutput("tone_out", toneOut, mTone);
        checkOutput("busy", busy, (mState != 0) ? 1 : 0);
        checkOutput("active_note", activeNote, mActive);
        checkOutput("req_err", reqErr, mErr);
    endtask

    task automatic applyStimulus(input int req, input int sel, input int oct, input int off);
        noteReq = req[0];
        noteSel = sel[3:0];
        octave  = oct[OCT_W-1:0];
        noteOff = off[0];
        tick();
        noteReq = 1'b0;
        noteOff = 1'b0;
    endtask

    task automatic measureLevel(input int level, output int len);
        len = 0;
        while (int'(toneOut) == level && len < 5000) begin
            tick();
            len++;
        end
    endtask

    initial begin
        int len;
        resetN = 1'b0; noteReq = 1'b0; noteSel = '0; octave = '0; noteOff = 1'b0;
        modelReset();
        #3;
        checkOutput("reset_tone", toneOut, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_active", activeNote, 0);
        checkOutput("reset_err", reqErr, 0);
        repeat (2) tick();
        resetN = 1'b1;
        repeat (3) tick();

        $display("[TB] C4 octave 0 level lengths");
        applyStimulus(1, 0, 0, 0);
        checkOutput("c4_rise", toneOut, 1);
        measureLevel(1, len);
        checkOutput("c4_high_len", len, 1911);
        measureLevel(0, len);
        checkOutput("c4_low_len", len, 1911);

        $display("[TB] note_off while high");
        repeat (10) tick();
        applyStimulus(0, 0, 0, 1);
        measureLevel(1, len);
        checkOutput("off_high_len", len + 11, 1911);
        checkOutput("off_tone", toneOut, 0);
        checkOutput("off_busy", busy, 0);
        checkOutput("off_active", activeNote, 0);

        $display("[TB] A4 octave 1 then octave 0 mid-play");
        repeat (5) tick();
        applyStimulus(1, 9, 1, 0);
        measureLevel(1, len);
        checkOutput("a4o1_high_len", len, 568);
        repeat (100) tick();
        applyStimulus(1, 9, 0, 0);
        measureLevel(0, len);
        checkOutput("a4o1_low_len", len + 101, 568);
        checkOutput("a4o0_active", activeNote, 9);
        measureLevel(1, len);
        checkOutput("a4o0_high_len", len, 1136);

        $display("[TB] request and note_off together");
        applyStimulus(1, 0, 3, 0);
        measureLevel(0, len);
        checkOutput("c4o3_prev_low", len + 1, 1136);
        repeat (20) tick();
        applyStimulus(1, 4, 3, 1);
        measureLevel(1, len);
        checkOutput("both_high_len", len + 21, 238);
        checkOutput("both_busy", busy, 1);
        checkOutput("both_active", activeNote, 4);

        $display("[TB] invalid note_sel");
        repeat (7) tick();
        applyStimulus(1, 13, 0, 0);
        checkOutput("inv_err", reqErr, 1);
        checkOutput("inv_active", activeNote, 4);
        checkOutput("inv_busy", busy, 1);
        tick();
        checkOutput("inv_err_clear", reqErr, 0);

        $display("[TB] async reset mid-play");
        repeat (9) tick();
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midrst_tone", toneOut, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_active", activeNote, 0);
        checkOutput("midrst_err", reqErr, 0);
        modelReset();
        repeat (2) tick();
        resetN = 1'b1;
        repeat (5) tick();
        checkOutput("postrst_busy", busy, 0);
        checkOutput("postrst_tone", toneOut, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            int gap, op;
            gap = $urandom_range(300, 0);
            repeat (gap) tick();
            op = $urandom_range(9, 0);
            if (op < 5)      applyStimulus(1, $urandom_range(11, 0), $urandom_range(3, 2), 0);
            else if (op < 6) applyStimulus(1, $urandom_range(15, 12), $urandom_range(3, 0), 0);
            else if (op < 8) applyStimulus(0, 0, 0, 1);
            else             applyStimulus(1, $urandom_range(11, 0), $urandom_range(3, 2), 1);
        end
        applyStimulus(0, 0, 0, 1);
        repeat (700) tick();
        checkOutput("drain_busy", busy, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
